rtc_alarm: RTL

RTC_ALARM -- requirements
Module: rtc_alarm

---
 rtl/rtc_alarm.sv | 81 ++++++++
 1 files changed

// File: rtl/rtc_alarm.sv
// rtc_alarm: real-time clock with a seconds/sub-second counter and N compare alarms.
// Ports: clk, rst_n (async active-low) | tick timebase pulse | wr_en/addr/data_in register write
//        data_out combinational register read | irq OR of enabled alarm flags | sec_pulse per second
module rtc_alarm #(
    parameter int TICKS_PER_SEC = 1000000,
    parameter int SEC_W = 32,
    parameter int N_ALARMS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        wr_en,
    input  logic [3:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        irq,
    output logic        sec_pulse
);
    localparam int SUB_W = $clog2(TICKS_PER_SEC);
    logic [SEC_W-1:0]    sec_q, sec_d, sec_inc;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic                run_q, run_d, pulse_q, pulse_d;
    logic [N_ALARMS-1:0] en_q, en_d, flag_q, flag_d, set, clr;
    logic [SEC_W-1:0]    alarm_q [N_ALARMS];
    logic [SEC_W-1:0]    alarm_d [N_ALARMS];
    logic                wr_sec, adv, roll, inc;
    always_comb begin
        wr_sec  = wr_en && addr == 4'h0;
        adv     = run_q && tick;
        roll    = adv && sub_q == SUB_W'(TICKS_PER_SEC - 1);
        // a SECONDS write discards any rollover in the same cycle, so no flag or pulse
        inc     = roll && !wr_sec;
        sec_inc = sec_q + SEC_W'(1);
        sub_d   = (wr_sec || roll) ? '0 : adv ? sub_q + SUB_W'(1) : sub_q;
        sec_d   = wr_sec ? data_in[SEC_W-1:0] : inc ? sec_inc : sec_q;
        pulse_d = inc;
        run_d   = (wr_en && addr == 4'h2) ? data_in[0] : run_q;
        en_d    = (wr_en && addr == 4'h2) ? data_in[8 +: N_ALARMS] : en_q;
        clr     = (wr_en && addr == 4'h3) ? data_in[N_ALARMS-1:0] : '0;
        set     = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            set[i]     = inc && sec_inc == alarm_q[i];
            alarm_d[i] = (wr_en && addr == 4'(4 + i)) ? data_in[SEC_W-1:0] : alarm_q[i];
        end
        // set is ORed in after the clear so a coincident set wins
        flag_d  = (flag_q & ~clr) | set;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q   <= '0;
            sub_q   <= '0;
            run_q   <= 1'b1;
            en_q    <= '0;
            flag_q  <= '0;
            pulse_q <= 1'b0;
            for (int i = 0; i < N_ALARMS; i++) alarm_q[i] <= '1;
        end else begin
            sec_q   <= sec_d;
            sub_q   <= sub_d;
            run_q   <= run_d;
            en_q    <= en_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_ALARMS; i++) alarm_q[i] <= alarm_d[i];
        end
    end
    always_comb begin
        data_out = '0;
        case (addr)
            4'h0:    data_out = 32'(sec_q);
            4'h1:    data_out = 32'(sub_q);
            4'h2:    data_out = 32'(run_q) | (32'(en_q) << 8);
            4'h3:    data_out = 32'(flag_q);
            default: ;
        endcase
        for (int i = 0; i < N_ALARMS; i++)
            if (addr == 4'(4 + i)) data_out = 32'(alarm_q[i]);
    end
    assign irq       = |(flag_q & en_q);
    assign sec_pulse = pulse_q;
endmodule
